// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with fractional-rate oversampling and mid-bit sampling.
// Ports:
//   clk          system clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   rx           raw serial line, idle high, asynchronous to clk
//   rx_data      last correctly framed byte, held until the next good byte
//   rx_valid     1-cycle pulse when rx_data is updated
//   rx_frame_err 1-cycle pulse when the stop bit is sampled low (byte discarded)
//   rx_busy      high whenever the receiver is not idle
module uart_rx #(
    parameter int unsigned clk_freq   = 12000000,
    parameter int unsigned baud       = 115200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);
    localparam int unsigned INC_I = baud * OVERSAMPLE;
    localparam int unsigned ACC_W = $clog2(clk_freq + INC_I + 1);
    localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
    localparam logic [ACC_W-1:0] INC     = ACC_W'(INC_I);
    localparam logic [ACC_W-1:0] LIM     = ACC_W'(clk_freq);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, rxs_q;
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic             tick, sample_done;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_frame_err_q, rx_frame_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sync1_q        <= 1'b1;
            rxs_q          <= 1'b1;
            acc_q          <= '0;
            sample_cnt_q   <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= rx;
            rxs_q          <= sync1_q;
            acc_q          <= acc_d;
            sample_cnt_q   <= sample_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_frame_err_q <= rx_frame_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        sample_cnt_d   = sample_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_frame_err_d = 1'b0;
        // Accumulator is held at zero while idle, so it starts clean on every frame.
        acc_sum     = acc_q + INC;
        tick        = (state_q != IDLE) && (acc_sum >= LIM);
        acc_d       = (state_q == IDLE) ? '0 : (tick ? acc_sum - LIM : acc_sum);
        // Start bit is judged half a bit in; every later sample is a full bit apart.
        sample_done = tick && (sample_cnt_q == ((state_q == START) ? HALF_M1 : FULL_M1));
        if (tick)
            sample_cnt_d = sample_done ? '0 : sample_cnt_q + CNT_W'(1);
        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d      = START;
                    sample_cnt_d = '0;
                end
            end
            START: begin
                if (sample_done) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = DATA;
                        sample_cnt_d = '0;
                        bit_cnt_d    = '0;
                    end
                end
            end
            DATA: begin
                if (sample_done) begin
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7)
                        state_d = STOP;
                end
            end
            STOP: begin
                if (sample_done) begin
                    if (rxs_q) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        rx_frame_err_d = 1'b1;
                        state_d        = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must return high before a new start is looked for.
                if (rxs_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_frame_err = rx_frame_err_q;
    assign rx_busy      = (state_q != IDLE);
endmodule
